// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes on both sides.
// Single-cycle logic/arith ops; iterative shift-add multiply and restoring divide.
`default_nettype none

module alu_mc #(
  parameter int N             = 32,
  parameter bit ENABLE_MULDIV = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] src_a,
  input  logic [N-1:0] src_b,
  input  logic [3:0]   alu_control,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] alu_result,
  output logic         zero_flag,
  output logic         neg_flag,
  output logic         carry_flag,
  output logic         ovf_flag,
  output logic         illegal_op
);

  localparam int SW = $clog2(N);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t         state, state_next;
  logic [SW-1:0]  cnt;
  logic [N-1:0]   opnd, hi, lo;
  logic           iter_div, iter_hi;

  logic           accept, is_mul, is_div, start_iter, last_step;
  logic [N:0]     sum, diff, mul_sum, div_sh, div_diff;
  logic [SW-1:0]  shamt;
  logic [N-1:0]   sc_result, hi_n, lo_n, fin;
  logic           sc_carry, sc_ovf, sc_illegal, div_ge;

  assign in_ready   = (state == IDLE) | ((state == DONE) & out_ready);
  assign out_valid  = (state == DONE);
  assign accept     = in_valid & in_ready & ~flush;
  assign is_mul     = ENABLE_MULDIV & (alu_control[3:1] == 3'b101);
  assign is_div     = ENABLE_MULDIV & (alu_control[3:1] == 3'b110);
  assign start_iter = is_mul | (is_div & (src_b != '0));
  assign last_step  = (cnt == SW'(N - 1));

  assign sum   = {1'b0, src_a} + {1'b0, src_b};
  assign diff  = {1'b0, src_a} - {1'b0, src_b};
  assign shamt = src_b[SW-1:0];

  always_comb begin
    sc_result  = '0;
    sc_carry   = 1'b0;
    sc_ovf     = 1'b0;
    sc_illegal = 1'b0;
    case (alu_control)
      4'b0000: begin
        sc_result = sum[N-1:0];
        sc_carry  = sum[N];
        sc_ovf    = (src_a[N-1] == src_b[N-1]) & (sum[N-1] != src_a[N-1]);
      end
      4'b0001: begin
        sc_result = diff[N-1:0];
        sc_carry  = ~diff[N];
        sc_ovf    = (src_a[N-1] != src_b[N-1]) & (diff[N-1] != src_a[N-1]);
      end
      4'b0010: sc_result = src_a & src_b;
      4'b0011: sc_result = src_a | src_b;
      4'b0100: sc_result = src_a ^ src_b;
      4'b0101: sc_result = {{(N-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      4'b0110: sc_result = {{(N-1){1'b0}}, (src_a < src_b)};
      4'b0111: sc_result = src_a << shamt;
      4'b1000: sc_result = src_a >> shamt;
      4'b1001: sc_result = $signed(src_a) >>> shamt;
      4'b1010, 4'b1011: sc_illegal = ~ENABLE_MULDIV;
      // Reached only for divide-by-zero when mul/div is enabled
      4'b1100: begin
        sc_illegal = ~ENABLE_MULDIV;
        sc_result  = ENABLE_MULDIV ? '1 : '0;
      end
      4'b1101: begin
        sc_illegal = ~ENABLE_MULDIV;
        sc_result  = ENABLE_MULDIV ? src_a : '0;
      end
      default: sc_illegal = 1'b1;
    endcase
  end

  // One iteration step: shift-add multiply or restoring divide over {hi, lo}
  assign mul_sum  = {1'b0, hi} + ({1'b0, opnd} & {(N+1){lo[0]}});
  assign div_sh   = {hi, lo[N-1]};
  assign div_diff = div_sh - {1'b0, opnd};
  assign div_ge   = ~div_diff[N];
  assign hi_n     = iter_div ? (div_ge ? div_diff[N-1:0] : div_sh[N-1:0]) : mul_sum[N:1];
  assign lo_n     = iter_div ? {lo[N-2:0], div_ge} : {mul_sum[0], lo[N-1:1]};
  assign fin      = iter_hi ? hi_n : lo_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = start_iter ? BUSY : DONE;
      BUSY: if (last_step) state_next = DONE;
      DONE: begin
        if (accept)         state_next = start_iter ? BUSY : DONE;
        else if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      opnd       <= '0;
      hi         <= '0;
      lo         <= '0;
      iter_div   <= 1'b0;
      iter_hi    <= 1'b0;
      alu_result <= '0;
      zero_flag  <= 1'b0;
      neg_flag   <= 1'b0;
      carry_flag <= 1'b0;
      ovf_flag   <= 1'b0;
      illegal_op <= 1'b0;
    end else if (flush) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
      if (start_iter) begin
        iter_div <= is_div;
        iter_hi  <= alu_control[0];
        opnd     <= is_mul ? src_a : src_b;
        hi       <= '0;
        lo       <= is_mul ? src_b : src_a;
      end else begin
        alu_result <= sc_result;
        zero_flag  <= ~sc_illegal & (sc_result == '0);
        neg_flag   <= sc_result[N-1];
        carry_flag <= sc_carry;
        ovf_flag   <= sc_ovf;
        illegal_op <= sc_illegal;
      end
    end else if (state == BUSY) begin
      cnt <= cnt + SW'(1);
      hi  <= hi_n;
      lo  <= lo_n;
      if (last_step) begin
        alu_result <= fin;
        zero_flag  <= (fin == '0);
        neg_flag   <= fin[N-1];
        carry_flag <= 1'b0;
        ovf_flag   <= 1'b0;
        illegal_op <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed plan items plus random ops against a reference model.
`default_nettype none

module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] src_a, src_b, alu_result;
  logic [3:0]  alu_control;
  logic        zero_flag, neg_flag, carry_flag, ovf_flag, illegal_op;

  logic        nm_in_valid, nm_in_ready, nm_out_valid;
  logic [31:0] nm_result;
  logic        nm_zero, nm_neg, nm_carry, nm_ovf, nm_illegal;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_mc #(.N(32), .ENABLE_MULDIV(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .src_a(src_a), .src_b(src_b), .alu_control(alu_control), .out_valid(out_valid),
    .out_ready(out_ready), .alu_result(alu_result), .zero_flag(zero_flag),
    .neg_flag(neg_flag), .carry_flag(carry_flag), .ovf_flag(ovf_flag), .illegal_op(illegal_op)
  );

  alu_mc #(.N(32), .ENABLE_MULDIV(1'b0)) dut_nm (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(nm_in_valid), .in_ready(nm_in_ready),
    .src_a(src_a), .src_b(src_b), .alu_control(alu_control), .out_valid(nm_out_valid),
    .out_ready(1'b1), .alu_result(nm_result), .zero_flag(nm_zero),
    .neg_flag(nm_neg), .carry_flag(nm_carry), .ovf_flag(nm_ovf), .illegal_op(nm_illegal)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour from the opcode table using wide integer arithmetic
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic c, output logic v,
                                output logic il, output int lat);
    logic [63:0] ua, ub, p;
    longint      sa, sb;
    ua = {32'b0, a};
    ub = {32'b0, b};
    sa = $signed(a);
    sb = $signed(b);
    p  = ua * ub;
    r = '0; c = 1'b0; v = 1'b0; il = 1'b0; lat = 1;
    case (op)
      4'd0: begin r = a + b; c = (ua + ub) > 64'hFFFF_FFFF; v = (sa + sb) != longint'($signed(r)); end
      4'd1: begin r = a - b; c = (a >= b); v = (sa - sb) != longint'($signed(r)); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd6: r = (a < b) ? 32'd1 : 32'd0;
      4'd7: r = a << b[4:0];
      4'd8: r = a >> b[4:0];
      4'd9: r = $signed(a) >>> b[4:0];
      4'd10: begin r = p[31:0];  lat = 33; end
      4'd11: begin r = p[63:32]; lat = 33; end
      4'd12: if (b == 0) r = 32'hFFFF_FFFF; else begin r = a / b; lat = 33; end
      4'd13: if (b == 0) r = a;             else begin r = a % b; lat = 33; end
      default: il = 1'b1;
    endcase
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    logic [31:0] er;
    logic        ec, ev, ei;
    int          elat, lat, rdy_busy;
    model(op, a, b, er, ec, ev, ei, elat);
    @(negedge clk);
    alu_control = op; src_a = a; src_b = b; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    rdy_busy = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      if (in_ready) rdy_busy++;
    end
    chk({tag, "/latency"},  64'(lat), 64'(elat));
    chk({tag, "/busy_rdy"}, 64'(rdy_busy), 64'd0);
    chk({tag, "/result"},   64'(alu_result), 64'(er));
    chk({tag, "/zero"},     64'(zero_flag), 64'(!ei && er == 0));
    chk({tag, "/neg"},      64'(neg_flag), 64'(er[31]));
    chk({tag, "/carry"},    64'(carry_flag), 64'(ec));
    chk({tag, "/ovf"},      64'(ovf_flag), 64'(ev));
    chk({tag, "/illegal"},  64'(illegal_op), 64'(ei));
  endtask

  task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    alu_control = op; src_a = a; src_b = b; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] held;
    int          seen;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; nm_in_valid = 1'b0;
    src_a = '0; src_b = '0; alu_control = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst/out_valid", 64'(out_valid), 64'd0);
    chk("rst/in_ready",  64'(in_ready), 64'd1);
    chk("rst/result",    64'(alu_result), 64'd0);
    chk("rst/flags",     64'({zero_flag, neg_flag, carry_flag, ovf_flag, illegal_op}), 64'd0);
    rst_n = 1'b1;

    run_op(4'd0, 32'h7FFF_FFFF, 32'h0000_0001, "add_ovf");

    // Back-to-back single-cycle ops with in_valid and out_ready held high
    @(negedge clk);
    alu_control = 4'd1; src_a = 32'd5; src_b = 32'd5; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("b2b/sub_valid", 64'(out_valid), 64'd1);
    chk("b2b/sub_res",   64'(alu_result), 64'd0);
    chk("b2b/sub_zc",    64'({zero_flag, carry_flag}), 64'b11);
    chk("b2b/rdy1",      64'(in_ready), 64'd1);
    alu_control = 4'd6; src_a = 32'd3; src_b = 32'd7;
    @(negedge clk);
    chk("b2b/sltu_res",  64'(alu_result), 64'd1);
    chk("b2b/rdy2",      64'(in_ready), 64'd1);
    alu_control = 4'd9; src_a = 32'h8000_0000; src_b = 32'd4;
    @(negedge clk);
    chk("b2b/sra_res",   64'(alu_result), 64'hF800_0000);
    chk("b2b/sra_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;

    run_op(4'd10, 32'hFFFF_FFFF, 32'h0000_0002, "mul");
    run_op(4'd11, 32'hFFFF_FFFF, 32'h0000_0002, "mulhu");
    run_op(4'd12, 32'd100, 32'd7, "divu");
    run_op(4'd13, 32'd100, 32'd7, "remu");
    run_op(4'd12, 32'd9, 32'd0, "divu0");
    run_op(4'd13, 32'd9, 32'd0, "remu0");
    run_op(4'd15, 32'h1234, 32'h5678, "illegal");

    // Backpressure: hold result while a competing request is presented
    @(negedge clk);
    alu_control = 4'd0; src_a = 32'hFFFF_FFFF; src_b = 32'd2; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 alu_control = 4'd3; src_a = 32'hF0; src_b = 32'h0F;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp/valid",  64'(out_valid), 64'd1);
      chk("bp/rdy",    64'(in_ready), 64'd0);
      chk("bp/result", 64'(alu_result), 64'd1);
      chk("bp/flags",  64'({zero_flag, neg_flag, carry_flag, ovf_flag}), 64'b0010);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp/next_res", 64'(alu_result), 64'hFF);
    chk("bp/next_val", 64'(out_valid), 64'd1);
    in_valid = 1'b0;

    // Asynchronous reset mid-multiply
    start_op(4'd10, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst/out_valid", 64'(out_valid), 64'd0);
    chk("arst/in_ready",  64'(in_ready), 64'd1);
    chk("arst/result",    64'(alu_result), 64'd0);
    chk("arst/flags",     64'({zero_flag, neg_flag, carry_flag, ovf_flag, illegal_op}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Flush mid-multiply: no result may ever appear
    start_op(4'd10, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush/in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    chk("flush/no_valid", 64'(seen), 64'd0);

    // flush in the same cycle as in_valid blocks the accept
    alu_control = 4'd0; src_a = 32'd1; src_b = 32'd1; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("flush/no_accept", 64'(out_valid), 64'd0);

    // Mul/div opcodes disabled
    alu_control = 4'd10; src_a = 32'd3; src_b = 32'd4; nm_in_valid = 1'b1;
    @(negedge clk);
    nm_in_valid = 1'b0;
    chk("nomd/valid",   64'(nm_out_valid), 64'd1);
    chk("nomd/illegal", 64'(nm_illegal), 64'd1);
    chk("nomd/result",  64'(nm_result), 64'd0);
    chk("nomd/flags",   64'({nm_zero, nm_neg, nm_carry, nm_ovf}), 64'd0);

    for (int i = 0; i < 40; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if (op >= 4'd12 && $urandom_range(0, 3) == 0) b = '0;
      if (op == 4'd1 && $urandom_range(0, 3) == 0) b = a;
      if (op >= 4'd12 && $urandom_range(0, 2) == 0) b = b >> $urandom_range(1, 31);
      run_op(op, a, b, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle successor to the processor's combinational ALU.
- Adds XOR, set-less-than, shifts, and iterative multiply/divide.
- Produces full condition flags and uses a valid/ready handshake on both sides, so the execute stage can stall on long operations.
- Sits between the ID/EX operand registers and the EX/MEM register.

Parameters:
N, 32, operand/result width in bits (even, >= 4); shift amount is src_b[$clog2(N)-1:0]
ENABLE_MULDIV, 1, 1 = mul/div opcodes implemented; 0 = those opcodes treated as illegal

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous abort of any in-flight or held operation
in_valid  input  1  operands/opcode valid
in_ready  output  1  block can accept an operation this cycle
src_a  input  N  operand A
src_b  input  N  operand B
alu_control  input  4  opcode (see Behaviour)
out_valid  output  1  result and flags valid
out_ready  input  1  consumer accepts result
alu_result  output  N  registered result
zero_flag  output  1  alu_result == 0
neg_flag  output  1  alu_result[N-1]
carry_flag  output  1  add: carry-out; sub: 1 when src_a >= src_b unsigned (no borrow); else 0
ovf_flag  output  1  signed overflow for add/sub; else 0
illegal_op  output  1  opcode was unassigned (or mul/div with ENABLE_MULDIV=0)

Behaviour:
- Clock and reset are fixed: one clock, clk; rst_n is asynchronous and active-low.
- Opcodes:
  - 0000 add, 0001 sub, 0010 and, 0011 or: codes match the previous ALU.
  - 0100 xor.
  - 0101 slt (signed), 0110 sltu: result is 0 or 1.
  - 0111 sll, 1000 srl, 1001 sra.
  - 1010 mul: low N bits of the unsigned product. 1011 mulhu: high N bits.
  - 1100 divu, 1101 remu.
  - 1110, 1111: illegal.
- Illegal opcode: alu_result = 0, all other flags 0, illegal_op = 1, single-cycle timing.
- States:
  - IDLE: in_ready=1.
  - BUSY: iterative mul/div in progress, in_ready=0.
  - DONE: out_valid=1, outputs held stable.
- Transitions:
  - Accept occurs on a rising edge with in_valid & in_ready. Operands and opcode are captured at that edge.
  - Single-cycle op: IDLE -> DONE. out_valid is high in the cycle after the accepting edge.
  - mul/mulhu/divu/remu: IDLE -> BUSY with cycle counter = 0. One shift-add or restoring-divide step per cycle.
  - BUSY -> DONE after exactly N steps. out_valid rises N+1 cycles after the accepting edge.
  - Divide by zero is detected at accept and skips BUSY (1-cycle latency). divu gives all ones; remu gives src_a.
  - DONE & out_ready with no new accept: -> IDLE.
  - in_ready = IDLE | (DONE & out_ready). An accept in DONE with out_ready=1 retires the old result and starts the new op on the same edge, giving back-to-back single-cycle ops at one per cycle.
  - DONE & !out_ready: hold result and flags indefinitely. in_ready=0.
- flush: synchronous. Has priority over every handshake. Next state is IDLE and out_valid goes to 0; partial mul/div state is discarded. flush with in_valid in the same cycle does not accept.
- Reset (including mid-BUSY): state IDLE, counter 0.
  - Outputs: out_valid=0, in_ready=1, alu_result=0, all flags 0, illegal_op=0.
  - Operation in progress is lost.
- Arithmetic:
  - add/sub are computed at N+1 bits for carry.
  - ovf for add = (a[N-1]==b[N-1]) & (r[N-1]!=a[N-1]).
  - ovf for sub = (a[N-1]!=b[N-1]) & (r[N-1]!=a[N-1]).
  - Shifts use only the low $clog2(N) bits of src_b. sra replicates src_a[N-1].
- zero_flag and neg_flag are derived from the final registered alu_result for every opcode.
- No X on any output in any state. Unused flags drive 0.

Test Plan:
- add 0x7FFFFFFF + 0x00000001, out_ready=1 -> after 1 cycle: result 0x80000000, neg=1, ovf=1, carry=0, zero=0.
- sub 5 - 5, then sltu 3,7, then sra 0x80000000 by 4, issued back-to-back with in_valid and out_ready held high:
  - results 0 (zero=1, carry=1), then 1, then 0xF8000000 on consecutive cycles.
  - in_ready stays 1 throughout.
- mul 0xFFFFFFFF * 0x00000002 -> in_ready=0 for N cycles; out_valid at cycle 33; result 0xFFFFFFFE.
  - mulhu with the same operands -> result 0x00000001.
- divu 100/7 -> quotient 14 at cycle 33; remu 100/7 -> 2.
  - divu 9/0 -> 0xFFFFFFFF at cycle 1; remu 9/0 -> 9.
- Backpressure: complete an add with out_ready=0 for 5 cycles -> result and flags stable, in_ready=0, new in_valid ignored; out_ready=1 -> retire, accept next.
- Interrupts:
  - rst_n low at BUSY step 10 of a mul -> all outputs 0, in_ready=1 immediately.
  - flush at BUSY step 10 -> IDLE next cycle, no out_valid.
  - opcode 1111 -> illegal_op=1, result 0.
  - With ENABLE_MULDIV=0, opcode 1010 -> illegal_op=1.
